// File: rtl/mac_result_drain.sv
// mac_result_drain: reader end of the 2x2 MAC array result interface.
// Captures one result per MAC lane into a result set, buffers complete sets
// in a DEPTH-entry FIFO and streams them out one word per lane, lane 0 first.
// Optional build macro: DRAIN_RELU_EN applies a signed ReLU to streamed words
// only (FIFO contents stay raw).
//
// Stream handshake: a word transfers on a rising edge where m_valid and
// m_ready are both high; once m_valid is high it stays high, and m_data,
// m_idx and m_last stay unchanged, until that transfer happens.
module mac_result_drain #(
    parameter int ACC_W  = 16,
    parameter int N_MACS = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ACC_W-1:0]  acc_in_0,
    input  logic [ACC_W-1:0]  acc_in_1,
    input  logic [ACC_W-1:0]  acc_in_2,
    input  logic [ACC_W-1:0]  acc_in_3,
    input  logic [N_MACS-1:0] valid_in,
    output logic [N_MACS-1:0] clear_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_data,
    output logic [1:0]        m_idx,
    output logic              m_last,
    output logic              full,
    output logic              overflow,
    output logic              dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE_SET = {{AW{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [1:0]         idx, idx_n;
    logic [ACC_W-1:0]   acc_arr [N_MACS];
    logic [ACC_W-1:0]   hold [N_MACS];
    logic [ACC_W-1:0]   mem [DEPTH][N_MACS];
    logic [N_MACS-1:0]  mask;
    logic [AW:0]        wr_ptr, rd_ptr, rd_nxt, used;
    logic               empty, set_done, push, pop, more;
    logic               load;
    logic [ACC_W-1:0]   load_word;

    assign acc_arr[0] = acc_in_0;
    assign acc_arr[1] = acc_in_1;
    assign acc_arr[2] = acc_in_2;
    assign acc_arr[3] = acc_in_3;

    // Streamed word shaping; the FIFO always keeps the raw value.
    function automatic logic [ACC_W-1:0] shape(input logic [ACC_W-1:0] w);
`ifdef DRAIN_RELU_EN
        return w[ACC_W-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Occupancy from wrap-bit pointers; a held set may push into the slot
    // freed by a pop on the same edge.
    assign used      = wr_ptr - rd_ptr;
    assign rd_nxt    = rd_ptr + ONE_SET;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign set_done  = &mask;
    assign pop       = (state == SEND) && m_ready && (idx == 2'd3);
    assign push      = set_done && (!full || pop);
    assign more      = (used > ONE_SET) || push;
    assign clear_out = {N_MACS{push}};
    assign m_valid   = (state == SEND);
    assign dbg_state = (state == SEND);

    // Lane capture: first value per lane wins until the set is pushed;
    // any re-fire before then is lost and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask     <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < N_MACS; i++) hold[i] <= '0;
        end else begin
            if (|(valid_in & mask)) overflow <= 1'b1;
            if (push) mask <= '0;
            else      mask <= mask | valid_in;
            for (int i = 0; i < N_MACS; i++) begin
                if (valid_in[i] && !mask[i]) hold[i] <= acc_arr[i];
            end
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE_SET;
            if (pop)  rd_ptr <= rd_nxt;
        end
    end

    // FIFO storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < N_MACS; i++) mem[wr_ptr[AW-1:0]][i] <= hold[i];
        end
    end

    // Output FSM next state and word selection. When the next set is being
    // pushed on the same edge as the pop, its lane 0 comes straight from hold.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        load      = 1'b0;
        load_word = '0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_n   = SEND;
                    idx_n     = 2'd0;
                    load      = 1'b1;
                    load_word = mem[rd_ptr[AW-1:0]][0];
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (idx != 2'd3) begin
                        idx_n     = idx + 2'd1;
                        load      = 1'b1;
                        load_word = mem[rd_ptr[AW-1:0]][idx_n];
                    end else if (more) begin
                        idx_n     = 2'd0;
                        load      = 1'b1;
                        load_word = (used > ONE_SET) ? mem[rd_nxt[AW-1:0]][0] : hold[0];
                    end else begin
                        state_n = IDLE;
                        idx_n   = 2'd0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state and registered stream word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            idx    <= 2'd0;
            m_data <= '0;
            m_idx  <= 2'd0;
            m_last <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (load) begin
                m_data <= shape(load_word);
                m_idx  <= idx_n;
                m_last <= (idx_n == 2'd3);
            end
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Testbench for mac_result_drain: directed scenarios plus randomized traffic
// checked against a set/queue level reference model.
module tb_mac_result_drain;

  localparam int W = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] acc_v [4];
  logic [3:0]   valid_in = '0;
  logic         m_ready = 1'b0;
  logic [3:0]   clear_out;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [1:0]   m_idx;
  logic         m_last;
  logic         full;
  logic         overflow;
  logic         dbg_state;

  mac_result_drain #(.ACC_W(W), .N_MACS(4), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .acc_in_0  (acc_v[0]),
    .acc_in_1  (acc_v[1]),
    .acc_in_2  (acc_v[2]),
    .acc_in_3  (acc_v[3]),
    .valid_in  (valid_in),
    .clear_out (clear_out),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_idx     (m_idx),
    .m_last    (m_last),
    .full      (full),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input logic [W-1:0] v);
`ifdef DRAIN_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // ---------------- reference model / scoreboard ----------------
  // Model state: lanes gathered for the set being built, number of sets the
  // FIFO holds, expected stream words in order, sticky loss flag.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pend_val [4];
  logic [3:0]   pend_mask = '0;
  int           fifo_cnt = 0;
  int           lane = 0;
  logic         m_ovf = 1'b0;
  logic         prev_valid = 1'b0;
  logic         prev_hs = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [1:0]   prev_idx = '0;
  logic         hs, pop_now, push_now;
  logic [W-1:0] w;

  // Runs mid-cycle: checks current outputs, then applies the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      pend_mask = '0;
      fifo_cnt = 0;
      lane = 0;
      m_ovf = 1'b0;
      prev_valid = 1'b0;
      prev_hs = 1'b0;
    end else begin
      hs = m_valid && m_ready;
      if (prev_valid && !prev_hs) begin
        check("valid_held", 32'(m_valid), 32'd1);
        check("data_stable", 32'(m_data), 32'(prev_data));
        check("idx_stable", 32'(m_idx), 32'(prev_idx));
      end
      check("valid_without_set", 32'(m_valid && (fifo_cnt == 0)), 32'd0);
      check("dbg_state", 32'(dbg_state), 32'(m_valid));
      check("full", 32'(full), 32'(fifo_cnt == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", 32'(m_valid), 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("data", 32'(m_data), 32'(w));
          check("idx", 32'(m_idx), 32'(lane));
          check("last", 32'(m_last), 32'(lane == 3));
        end
      end
      pop_now = hs && (lane == 3);
      if (hs) lane = (lane + 1) % 4;
      push_now = (pend_mask == 4'hF) && ((fifo_cnt < DEPTH) || pop_now);
      check("clear_out", 32'(clear_out), push_now ? 32'hF : 32'h0);
      if (push_now) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_word(pend_val[i]));
        fifo_cnt++;
        pend_mask = '0;
        if (valid_in != '0) m_ovf = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (valid_in[i]) begin
            if (pend_mask[i]) m_ovf = 1'b1;
            else begin
              pend_val[i] = acc_v[i];
              pend_mask[i] = 1'b1;
            end
          end
        end
      end
      if (pop_now) fifo_cnt--;
      prev_valid = m_valid;
      prev_hs = hs;
      prev_data = m_data;
      prev_idx = m_idx;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_acc(input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] a2, input logic [W-1:0] a3);
    acc_v[0] = a0;
    acc_v[1] = a1;
    acc_v[2] = a2;
    acc_v[3] = a3;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    valid_in = '0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || pend_mask == 4'hF) && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_drain", 32'(m_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clear"}, 32'(clear_out), 32'd0);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_data"}, 32'(m_data), 32'd0);
    check({tag, "_idx"}, 32'(m_idx), 32'd0);
    check({tag, "_last"}, 32'(m_last), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  task automatic midreset();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    valid_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_valid", 32'(m_valid), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4; i++) acc_v[i] = '0;
    #2 rst = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    m_ready = 1'b1;

    // Single set with latency and clear pulse timing.
    @(posedge clk); #1;
    set_acc(16'd5, 16'hFFFD, 16'd100, 16'hFFFF);
    valid_in = 4'hF;
    @(posedge clk); #1;
    valid_in = '0;
    check("lat_clear_k", 32'(clear_out), 32'hF);
    check("lat_valid_k", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_clear_k1", 32'(clear_out), 32'h0);
    check("lat_valid_k1", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid_k2", 32'(m_valid), 32'd1);
    check("lat_data_k2", 32'(m_data), 32'(exp_word(16'd5)));
    drain(50);

    // Staggered lanes.
    @(posedge clk); #1;
    set_acc(16'd7, 16'd0, 16'd0, 16'd0);
    valid_in = 4'b0001;
    @(posedge clk); #1;
    set_acc(16'd0, 16'd8, 16'd9, 16'd0);
    valid_in = 4'b0110;
    @(posedge clk); #1;
    check("stagger_no_clear", 32'(clear_out), 32'h0);
    set_acc(16'd0, 16'd0, 16'd0, 16'd10);
    valid_in = 4'b1000;
    @(posedge clk); #1;
    valid_in = '0;
    check("stagger_clear", 32'(clear_out), 32'hF);
    drain(50);

    // Backpressure until full, fifth set held.
    m_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      set_acc(16'(s * 4 + 1), 16'(s * 4 + 2), 16'(s * 4 + 3), 16'(s * 4 + 4));
      valid_in = 4'hF;
      @(posedge clk); #1;
      valid_in = '0;
      @(posedge clk); #1;
      if (s == 3) check("full_after_4", 32'(full), 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("bp_full", 32'(full), 32'd1);
    check("bp_no_clear", 32'(clear_out), 32'h0);
    check("bp_head", 32'(m_data), 32'(exp_word(16'd1)));
    drain(100);

    // Lane 2 re-fires before the set completes.
    @(posedge clk); #1;
    set_acc(16'd0, 16'd0, 16'd11, 16'd0);
    valid_in = 4'b0100;
    @(posedge clk); #1;
    set_acc(16'd0, 16'd0, 16'd22, 16'd0);
    valid_in = 4'b0100;
    @(posedge clk); #1;
    set_acc(16'd1, 16'd2, 16'd33, 16'd4);
    valid_in = 4'b1011;
    @(posedge clk); #1;
    valid_in = '0;
    check("ovf_set", 32'(overflow), 32'd1);
    drain(50);

    // Signed boundary values through the word shaping.
    @(posedge clk); #1;
    set_acc(16'hFFFC, 16'd0, 16'd3, 16'h8000);
    valid_in = 4'hF;
    @(posedge clk); #1;
    valid_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("relu_w0", 32'(m_data), 32'(exp_word(16'hFFFC)));
    drain(50);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (i == 700) midreset();
      for (int l = 0; l < 4; l++) acc_v[l] = 16'($urandom_range(0, 65535));
      valid_in = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      m_ready = ($urandom_range(0, 3) != 0);
    end
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
